// File: rtl/npu_pkg.sv
// Shared NPU definitions: MAC engine state encoding, default datapath widths
// and the minimum accumulator width helper.
package npu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned PIXEL_WIDTH_DEF       = 8;
  localparam int unsigned WEIGHT_WIDTH_DEF      = 8;
  localparam int unsigned KERNEL_ADDR_WIDTH_DEF = 6;

  // Smallest accumulator that cannot overflow when summing k*k full-scale products.
  function automatic int unsigned acc_width_min(input int unsigned k,
                                                input int unsigned pw,
                                                input int unsigned ww);
    return pw + ww + $clog2(k * k);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate with synchronous clear and enable; o_sum is the
// value the accumulator takes on the next enabled edge.
module mac_unit
  import npu_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = PIXEL_WIDTH_DEF,
  parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH    = acc_width_min(3, PIXEL_WIDTH_DEF, WEIGHT_WIDTH_DEF)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic [PIXEL_WIDTH-1:0]  i_pixel,
  input  logic [WEIGHT_WIDTH-1:0] i_weight,
  output logic [ACC_WIDTH-1:0]    o_sum
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_prod;

  assign w_prod = ACC_WIDTH'(i_pixel) * ACC_WIDTH'(i_weight);
  assign o_sum  = r_acc + w_prod;

  // Accumulator register: clear wins over accumulate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end else begin
      r_acc <= r_acc;
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// KxK convolution dot-product engine: one tap per cycle against the kernel store.
// Optional output shift/clamp to pixel range is enabled by CONV_MAC_OUT_SAT_EN.
module conv_mac_engine
  import npu_pkg::*;
#(
  parameter int unsigned K                 = 3,
  parameter int unsigned PIXEL_WIDTH       = PIXEL_WIDTH_DEF,
  parameter int unsigned WEIGHT_WIDTH      = WEIGHT_WIDTH_DEF,
  parameter int unsigned KERNEL_ADDR_WIDTH = KERNEL_ADDR_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH         = acc_width_min(3, PIXEL_WIDTH_DEF, WEIGHT_WIDTH_DEF),
  parameter int unsigned OUT_SHIFT         = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [K*K*PIXEL_WIDTH-1:0]     in_window,
  input  logic [KERNEL_ADDR_WIDTH-1:0]   k_base,
  output logic [KERNEL_ADDR_WIDTH-1:0]   k_rd_addr,
  input  logic [WEIGHT_WIDTH-1:0]        k_rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_WIDTH-1:0]           out_result,
  output logic                           busy
);

  localparam int unsigned TAPS  = K * K;
  localparam int unsigned IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(TAPS - 1);
  localparam logic [ACC_WIDTH-1:0] PIX_MAX  = ACC_WIDTH'((64'd1 << PIXEL_WIDTH) - 64'd1);

  state_e                         r_state;
  state_e                         w_state_nxt;
  logic [IDX_W-1:0]               r_idx;
  logic [TAPS*PIXEL_WIDTH-1:0]    r_window;
  logic [KERNEL_ADDR_WIDTH-1:0]   r_addr;
  logic                           r_out_valid;
  logic [ACC_WIDTH-1:0]           r_result;
  logic                           w_accept;
  logic                           w_last;
  logic                           w_mac_en;
  logic [PIXEL_WIDTH-1:0]         w_pixel;
  logic [ACC_WIDTH-1:0]           w_sum;
  logic [ACC_WIDTH-1:0]           w_final;

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign k_rd_addr  = r_addr;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;

  assign w_accept = in_valid && in_ready;
  assign w_mac_en = (r_state == MAC);
  assign w_last   = w_mac_en && (r_idx == LAST_IDX);
  assign w_pixel  = r_window[int'(r_idx) * PIXEL_WIDTH +: PIXEL_WIDTH];

  mac_unit #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_accept),
    .i_en     (w_mac_en),
    .i_pixel  (w_pixel),
    .i_weight (k_rd_data),
    .o_sum    (w_sum)
  );

`ifdef CONV_MAC_OUT_SAT_EN
  logic [ACC_WIDTH-1:0] w_shifted;
  assign w_shifted = w_sum >> OUT_SHIFT;
  assign w_final   = (w_shifted > PIX_MAX) ? PIX_MAX : w_shifted;
`else
  // Shift is meaningless without the clamp, so it is forced to zero here.
  localparam int unsigned SHIFT_EFF = 0 * OUT_SHIFT;
  logic w_unused_max;
  assign w_unused_max = ^PIX_MAX;
  assign w_final      = w_sum >> SHIFT_EFF;
`endif

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_accept ? MAC : IDLE;
      MAC:     w_state_nxt = w_last ? DONE : MAC;
      DONE:    w_state_nxt = out_ready ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, sequencing and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_window    <= '0;
      r_addr      <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_window <= in_window;
            r_addr   <= k_base;
            r_idx    <= '0;
          end
        end
        MAC: begin
          if (w_last) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
          end else begin
            r_idx  <= r_idx + IDX_W'(1);
            r_addr <= r_addr + KERNEL_ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed self-checking bench for conv_mac_engine: table of windows plus
// hand-written stall and mid-MAC reset sequences.
module tb_conv_mac_engine;

  localparam int K   = 3;
  localparam int PW  = 8;
  localparam int WW  = 8;
  localparam int KAW = 6;
  localparam int AW  = 20;
`ifdef CONV_MAC_OUT_SAT_EN
  localparam int SH = 2;
`else
  localparam int SH = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [K*K*PW-1:0] in_window;
  logic [KAW-1:0]    k_base;
  logic [KAW-1:0]    k_rd_addr;
  logic [WW-1:0]     k_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_result;
  logic              busy;

  logic [WW-1:0] mem [64];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign k_rd_data = mem[k_rd_addr];

  conv_mac_engine #(
    .K(K), .PIXEL_WIDTH(PW), .WEIGHT_WIDTH(WW), .KERNEL_ADDR_WIDTH(KAW),
    .ACC_WIDTH(AW), .OUT_SHIFT(SH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_window(in_window), .k_base(k_base), .k_rd_addr(k_rd_addr),
    .k_rd_data(k_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
  );

  typedef struct {
    int         win_mode;
    int         ker_mode;
    logic [5:0] base;
    int         raw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_res(input int raw);
    int v;
`ifdef CONV_MAC_OUT_SAT_EN
    v = raw >> SH;
    if (v > 255) v = 255;
`else
    v = raw;
`endif
    return v;
  endfunction

  function automatic logic [K*K*PW-1:0] mkwin(input int mode);
    logic [K*K*PW-1:0] w;
    w = '0;
    for (int i = 0; i < K*K; i++) begin
      if (mode == 0)      w[i*PW +: PW] = 8'd1;
      else if (mode == 1) w[i*PW +: PW] = PW'(i + 1);
      else                w[i*PW +: PW] = 8'd255;
    end
    return w;
  endfunction

  task automatic load_kernel(input int mode);
    logic [7:0] kv [9];
    kv = '{8'd3, 8'd1, 8'd5, 8'd2, 8'd4, 8'd2, 8'd5, 8'd1, 8'd3};
    for (int a = 0; a < 64; a++) mem[a] = 8'd0;
    if (mode == 0) begin
      for (int a = 0; a < 9; a++) mem[a] = kv[a];
    end else begin
      for (int a = 60; a < 64; a++) mem[a] = 8'd1;
      for (int a = 0; a < 5; a++) mem[a] = 8'd1;
    end
  endtask

  // Present one window, check addresses and latency, then check the result.
  task automatic run_window(input logic [K*K*PW-1:0] win, input logic [5:0] base,
                            input int raw, input bit release_out);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before", 32'(in_ready), 32'd1);
    in_window = win;
    k_base    = base;
    in_valid  = 1'b1;
    n = 0;
    while (n < 40 && !out_valid) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        in_valid = 1'b0;
        chk("mac_in_ready", 32'(in_ready), 32'd0);
        chk("mac_busy", 32'(busy), 32'd1);
      end
      if (n >= 1 && n <= 9) chk("k_rd_addr", 32'(k_rd_addr), 32'((int'(base) + n - 1) & 63));
    end
    chk("latency", n, 32'd10);
    chk("result", 32'(out_result), exp_res(raw));
    chk("done_busy", 32'(busy), 32'd1);
    if (release_out) begin
      @(posedge clk); #1;
      chk("post_out_valid", 32'(out_valid), 32'd0);
      chk("post_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    vec_t tbl[4];
    int   n;
    tbl[0] = '{win_mode: 0, ker_mode: 0, base: 6'd0,  raw: 26};
    tbl[1] = '{win_mode: 1, ker_mode: 0, base: 6'd0,  raw: 130};
    tbl[2] = '{win_mode: 2, ker_mode: 0, base: 6'd0,  raw: 6630};
    tbl[3] = '{win_mode: 1, ker_mode: 1, base: 6'd60, raw: 45};

    rst = 1'b1; in_valid = 1'b0; in_window = '0; k_base = '0; out_ready = 1'b1;
    load_kernel(0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_k_rd_addr", 32'(k_rd_addr), 32'd0);

    for (int v = 0; v < 4; v++) begin
      load_kernel(tbl[v].ker_mode);
      run_window(mkwin(tbl[v].win_mode), tbl[v].base, tbl[v].raw, 1'b1);
    end

    // Back-pressure in DONE with a competing window offered.
    load_kernel(0);
    out_ready = 1'b0;
    run_window(mkwin(1), 6'd0, 130, 1'b0);
    in_window = mkwin(0);
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_result", 32'(out_result), exp_res(130));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("no_stray_accept", 32'(busy), 32'd0);

    // Reset four cycles into MAC.
    in_window = mkwin(1);
    k_base    = 6'd0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_result", 32'(out_result), 32'd0);
    chk("abort_k_rd_addr", 32'(k_rd_addr), 32'd0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("abort_no_result", n, 32'd0);
    run_window(mkwin(0), 6'd0, 26, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
